// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle control sequencer:
// FSM states, opcodes, instruction classes, immediate formats and status codes.
package rv_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_t;

    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_OPIMM  = 7'h13;
    localparam logic [6:0] OP_OP     = 7'h33;

    localparam logic [3:0] CLS_ILLEGAL = 4'd0;
    localparam logic [3:0] CLS_LUI     = 4'd1;
    localparam logic [3:0] CLS_AUIPC   = 4'd2;
    localparam logic [3:0] CLS_JAL     = 4'd3;
    localparam logic [3:0] CLS_JALR    = 4'd4;
    localparam logic [3:0] CLS_BRANCH  = 4'd5;
    localparam logic [3:0] CLS_LOAD    = 4'd6;
    localparam logic [3:0] CLS_STORE   = 4'd7;
    localparam logic [3:0] CLS_OPIMM   = 4'd8;
    localparam logic [3:0] CLS_OP      = 4'd9;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [1:0] PCSEL_PC4     = 2'd0;
    localparam logic [1:0] PCSEL_OPC_IMM = 2'd1;
    localparam logic [1:0] PCSEL_ALU     = 2'd2;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

endpackage

// File: rtl/rv_ctrl_decode.sv
// Combinational opcode classifier: instruction class, immediate format,
// ALU operand selects and a legal-opcode flag.
module rv_ctrl_decode
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output logic [3:0] cls,
    output logic [2:0] imm_sel,
    output logic       alu_src,
    output logic       alu_asel,
    output logic       legal
);

    always_comb begin
        cls      = CLS_ILLEGAL;
        imm_sel  = IMM_I;
        alu_src  = 1'b0;
        alu_asel = 1'b0;
        case (opcode)
            OP_LUI:    begin cls = CLS_LUI;    imm_sel = IMM_U; alu_src = 1'b1; end
            OP_AUIPC:  begin cls = CLS_AUIPC;  imm_sel = IMM_U; alu_src = 1'b1; alu_asel = 1'b1; end
            OP_JAL:    begin cls = CLS_JAL;    imm_sel = IMM_J; alu_src = 1'b1; end
            OP_JALR:   begin cls = CLS_JALR;   imm_sel = IMM_I; alu_src = 1'b1; end
            OP_BRANCH: begin cls = CLS_BRANCH; imm_sel = IMM_B; end
            OP_LOAD:   begin cls = CLS_LOAD;   imm_sel = IMM_I; alu_src = 1'b1; end
            OP_STORE:  begin cls = CLS_STORE;  imm_sel = IMM_S; alu_src = 1'b1; end
            OP_OPIMM:  begin cls = CLS_OPIMM;  imm_sel = IMM_I; alu_src = 1'b1; end
            OP_OP:     begin cls = CLS_OP;     imm_sel = IMM_I; end
            default:   ;
        endcase
    end

    assign legal = (cls != CLS_ILLEGAL);

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer sharing one memory port
// between fetch and load/store, with timeout trap and retired-instruction count.
module rv_multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             br_cond,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             mdr_we,
    output logic [2:0]       ImmSel,
    output logic             ALUsrc,
    output logic             alu_asel,
    output logic             RegW,
    output logic             memtoreg,
    output logic             LUItoReg,
    output logic             jumplink,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instret,
    output logic [2:0]       state_o
);

    localparam logic [7:0] TIMEOUT_LIM = MEM_TIMEOUT[7:0];

    state_t           state_reg, state_next;
    logic [7:0]       wait_cnt_reg, wait_cnt_next;
    logic [CNT_W-1:0] instret_reg;
    logic [1:0]       cause_reg, cause_next;
    logic [3:0]       cls_reg;
    logic [2:0]       imm_sel_reg;
    logic             alu_src_reg, alu_asel_reg;

    logic [3:0] dec_cls;
    logic [2:0] dec_imm_sel;
    logic       dec_alu_src, dec_alu_asel, dec_legal;

    rv_ctrl_decode u_decode (
        .opcode   (opcode),
        .cls      (dec_cls),
        .imm_sel  (dec_imm_sel),
        .alu_src  (dec_alu_src),
        .alu_asel (dec_alu_asel),
        .legal    (dec_legal)
    );

    // Decode is live in DECODE and latched for the rest of the instruction.
    logic [3:0] cur_cls;
    logic       in_decode;
    assign in_decode = (state_reg == ST_DECODE);
    assign cur_cls   = in_decode ? dec_cls : cls_reg;

    logic       timeout_hit;
    logic [7:0] wait_cnt_inc;
    assign wait_cnt_inc = wait_cnt_reg + 8'd1;
    assign timeout_hit  = (wait_cnt_inc == TIMEOUT_LIM);

    logic       mem_req_c, mem_we_c, ir_we_c, pc_we_c, mdr_we_c;
    logic       reg_w_c, memtoreg_c, lui_c, jumplink_c, sel_act_c, retire;
    logic [1:0] pc_sel_c;

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = 8'd0;
        cause_next    = cause_reg;
        retire        = 1'b0;
        mem_req_c     = 1'b0;
        mem_we_c      = 1'b0;
        ir_we_c       = 1'b0;
        pc_we_c       = 1'b0;
        pc_sel_c      = PCSEL_PC4;
        mdr_we_c      = 1'b0;
        reg_w_c       = 1'b0;
        memtoreg_c    = 1'b0;
        lui_c         = 1'b0;
        jumplink_c    = 1'b0;
        sel_act_c     = 1'b0;
        case (state_reg)
            ST_IDLE: state_next = ST_FETCH;
            ST_FETCH: begin
                mem_req_c = 1'b1;
                if (mem_ack) begin
                    ir_we_c    = 1'b1;
                    pc_we_c    = 1'b1;
                    state_next = ST_DECODE;
                end else if (timeout_hit) begin
                    cause_next = CAUSE_TIMEOUT;
                    state_next = ST_TRAP;
                end else begin
                    wait_cnt_next = wait_cnt_inc;
                end
            end
            ST_DECODE: begin
                sel_act_c = 1'b1;
                if (dec_legal) begin
                    state_next = ST_EXEC;
                end else begin
                    cause_next = CAUSE_ILLEGAL;
                    state_next = ST_TRAP;
                end
            end
            ST_EXEC: begin
                sel_act_c = 1'b1;
                if (cur_cls == CLS_BRANCH) begin
                    pc_we_c    = br_cond;
                    pc_sel_c   = br_cond ? PCSEL_OPC_IMM : PCSEL_PC4;
                    retire     = 1'b1;
                    state_next = ST_FETCH;
                end else if (cur_cls == CLS_LOAD || cur_cls == CLS_STORE) begin
                    state_next = ST_MEM;
                end else begin
                    state_next = ST_WB;
                end
            end
            ST_MEM: begin
                sel_act_c = 1'b1;
                mem_req_c = 1'b1;
                mem_we_c  = (cur_cls == CLS_STORE);
                if (mem_ack) begin
                    if (cur_cls == CLS_STORE) begin
                        retire     = 1'b1;
                        state_next = ST_FETCH;
                    end else begin
                        mdr_we_c   = 1'b1;
                        state_next = ST_WB;
                    end
                end else if (timeout_hit) begin
                    cause_next = CAUSE_TIMEOUT;
                    state_next = ST_TRAP;
                end else begin
                    wait_cnt_next = wait_cnt_inc;
                end
            end
            ST_WB: begin
                sel_act_c  = 1'b1;
                reg_w_c    = 1'b1;
                memtoreg_c = (cur_cls == CLS_LOAD);
                lui_c      = (cur_cls == CLS_LUI);
                jumplink_c = (cur_cls == CLS_JAL) || (cur_cls == CLS_JALR);
                if (cur_cls == CLS_JAL) begin
                    pc_we_c  = 1'b1;
                    pc_sel_c = PCSEL_OPC_IMM;
                end else if (cur_cls == CLS_JALR) begin
                    pc_we_c  = 1'b1;
                    pc_sel_c = PCSEL_ALU;
                end
                retire     = 1'b1;
                state_next = ST_FETCH;
            end
            ST_TRAP: state_next = ST_TRAP;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            wait_cnt_reg <= 8'd0;
            instret_reg  <= '0;
            cause_reg    <= CAUSE_NONE;
            cls_reg      <= CLS_ILLEGAL;
            imm_sel_reg  <= IMM_I;
            alu_src_reg  <= 1'b0;
            alu_asel_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            cause_reg    <= cause_next;
            if (in_decode) begin
                cls_reg      <= dec_cls;
                imm_sel_reg  <= dec_imm_sel;
                alu_src_reg  <= dec_alu_src;
                alu_asel_reg <= dec_alu_asel;
            end
            if (retire) begin
                instret_reg <= instret_reg + 1'b1;
            end
        end
    end

    // Everything the datapath acts on is forced low during a reset cycle.
    logic [2:0] imm_sel_c;
    logic       alu_src_c, alu_asel_c;
    assign imm_sel_c  = in_decode ? dec_imm_sel  : imm_sel_reg;
    assign alu_src_c  = in_decode ? dec_alu_src  : alu_src_reg;
    assign alu_asel_c = in_decode ? dec_alu_asel : alu_asel_reg;

    assign mem_req    = rst_n & mem_req_c;
    assign mem_we     = rst_n & mem_we_c;
    assign ir_we      = rst_n & ir_we_c;
    assign pc_we      = rst_n & pc_we_c;
    assign pc_sel     = rst_n ? pc_sel_c : 2'd0;
    assign mdr_we     = rst_n & mdr_we_c;
    assign ImmSel     = (rst_n && sel_act_c) ? imm_sel_c : 3'd0;
    assign ALUsrc     = rst_n & sel_act_c & alu_src_c;
    assign alu_asel   = rst_n & sel_act_c & alu_asel_c;
    assign RegW       = rst_n & reg_w_c;
    assign memtoreg   = rst_n & memtoreg_c;
    assign LUItoReg   = rst_n & lui_c;
    assign jumplink   = rst_n & jumplink_c;
    assign trap       = rst_n & (state_reg == ST_TRAP);
    assign trap_cause = rst_n ? cause_reg : CAUSE_NONE;
    assign instret    = instret_reg;
    assign state_o    = state_reg;

endmodule

// File: doc/rv_multicycle_ctrl.md
Name: rv_multicycle_ctrl

Overview:
Multi-cycle control sequencer for the RV32I core. It replaces the single-cycle control unit's one-shot decode with an FSM that steps each instruction through FETCH/DECODE/EXEC/MEM/WB. It shares one memory port between instruction fetch and load/store via a req/ack handshake. It drives the datapath enables and the existing mux selects (ImmSel, ALUsrc, memtoreg, LUItoReg, jumplink, RegW).

Parameters:
MEM_TIMEOUT, 15, max cycles to wait for mem_ack before trapping (1..255)
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
opcode  in  7  IR[6:0] from instruction register
br_cond  in  1  branch comparator result, valid in EXEC
mem_ack  in  1  memory completion strobe, one cycle
mem_req  out  1  memory request, held until ack
mem_we  out  1  store when 1, read when 0; valid with mem_req
ir_we  out  1  latch fetched word into IR and old PC into OPC
pc_we  out  1  PC write enable
pc_sel  out  2  0=PC+4, 1=OPC+imm, 2=ALU result (JALR)
mdr_we  out  1  latch load data
ImmSel  out  3  immediate format
ALUsrc  out  1  ALU B = imm when 1
alu_asel  out  1  ALU A = OPC when 1 (AUIPC)
RegW  out  1  register file write
memtoreg  out  1  WB data = MDR
LUItoReg  out  1  WB data = imm
jumplink  out  1  WB data = OPC+4
trap  out  1  sticky fault flag
trap_cause  out  2  0=none, 1=illegal opcode, 2=mem timeout
instret  out  CNT_W  retired-instruction count
state_o  out  3  current state, debug

Behaviour:
- Clock and reset: one clock clk; synchronous active-low reset rst_n, sampled on the rising clock edge.
- Reset: state=IDLE, instret=0, trap=0, trap_cause=0, wait counter=0. All outputs are 0 while rst_n=0 and in IDLE.
- IDLE -> FETCH unconditionally on the first clock edge after reset is released.
- FETCH: mem_req=1, mem_we=0. On mem_ack=1: ir_we=1, pc_we=1, pc_sel=0; go to DECODE. Otherwise stay.
- DECODE (1 cycle): classify opcode. LUI=0x37, AUIPC=0x17, JAL=0x6F, JALR=0x67, BRANCH=0x63, LOAD=0x03, STORE=0x23, OPIMM=0x13, OP=0x33. Any other value -> TRAP with cause=1. Otherwise go to EXEC.
- ImmSel: I for LOAD/OPIMM/JALR, S for STORE, B for BRANCH, U for LUI/AUIPC, J for JAL. Held constant from DECODE through WB. ALUsrc=1 for all except OP and BRANCH. alu_asel=1 only for AUIPC.
- EXEC (1 cycle):
  - BRANCH: if br_cond, pc_we=1 with pc_sel=1. Then retire and go to FETCH.
  - LOAD/STORE: go to MEM.
  - All others: go to WB.
- MEM: mem_req=1, mem_we=1 for STORE. The wait counter starts at 0 on entry and increments each cycle without ack.
  - On ack, LOAD: mdr_we=1, go to WB.
  - On ack, STORE: retire, go to FETCH.
  - Counter reaching MEM_TIMEOUT with no ack -> TRAP with cause=2. The same counter and rule apply in FETCH.
- WB (1 cycle): RegW=1. memtoreg=1 for LOAD, LUItoReg=1 for LUI, jumplink=1 for JAL/JALR. JAL: pc_we=1, pc_sel=1. JALR: pc_we=1, pc_sel=2. Retire, go to FETCH.
- Retire: instret increments by 1 in the retiring cycle and wraps modulo 2^CNT_W.
- TRAP: absorbing state. trap=1, cause held, all enables and mem_req=0. Only rst_n exits.
- Handshake:
  - mem_req and mem_we are stable from request start until the ack cycle. mem_req drops in the cycle after ack.
  - Back-to-back requests are allowed: a STORE ack is followed by a FETCH req next cycle.
  - mem_ack while mem_req=0 is ignored.
  - Ack arriving in the same cycle the counter hits MEM_TIMEOUT counts as success; ack wins.
- Reset mid-operation: abort at the next edge, with no enables asserted in the reset cycle.
- Minimum latency in cycles: OP = 4 (FETCH with 1-cycle ack, DECODE, EXEC, WB); BRANCH = 3; STORE = 4; LOAD = 5.

Decomposition:
- rv_ctrl_pkg holds:
  - state encoding (IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6)
  - opcode constants
  - ImmSel encoding (I=0, S=1, B=2, U=3, J=4)
  - pc_sel and trap_cause codes
- One natural sub-module, rv_ctrl_decode: combinational opcode -> instruction class, ImmSel, ALUsrc, alu_asel, legal flag.
- FSM, wait counter and instret stay in the top module.

Test Plan:
- Reset then OPIMM 0x13, mem_ack after 1 cycle -> state sequence IDLE,FETCH,DECODE,EXEC,WB,FETCH; RegW=1 only in WB; ImmSel=0, ALUsrc=1; instret=1.
- LOAD 0x03, fetch ack delayed 3 cycles, data ack after 2 -> mem_req held 4 then 3 cycles; mem_we=0; mdr_we pulses once; memtoreg=1 with RegW in WB; instret=1.
- STORE 0x23 then BRANCH 0x63 with br_cond=1, then BRANCH with br_cond=0 -> store has mem_we=1 and no RegW; taken branch pc_we=1, pc_sel=1 in EXEC; not-taken branch has no pc_we in EXEC; instret=3.
- JAL 0x6F then JALR 0x67 -> WB shows RegW=1, jumplink=1, pc_we=1 with pc_sel=1 and pc_sel=2 respectively; ImmSel=4 then 0.
- Opcode 0x7F -> TRAP after DECODE, trap=1, trap_cause=1, mem_req stays 0 for 20 cycles; rst_n=0 for one cycle clears trap, instret=0.
- MEM_TIMEOUT=15, no ack in FETCH -> trap_cause=2 after 15 req cycles. Repeat with ack on the 15th cycle -> no trap, DECODE next.
